// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decode, scoreboard hazard stall and registered ID/EX issue
module decode_issue_stage #(
   parameter int DATA_W = 16,
   parameter int NREG_LOG2 = 3,
   localparam int NREG = 1 << NREG_LOG2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 InValid,
   output logic                 InReady,
   input  logic [15:0]          InInstr,
   output logic [NREG_LOG2-1:0] RfReadRegister1,
   output logic [NREG_LOG2-1:0] RfReadRegister2,
   input  logic [DATA_W-1:0]    RfReadData1,
   input  logic [DATA_W-1:0]    RfReadData2,
   input  logic                 WbEnable,
   input  logic [NREG_LOG2-1:0] WbRegister,
   input  logic                 Flush,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [4:0]           OutOpcode,
   output logic [NREG_LOG2-1:0] OutDst,
   output logic                 OutWrites,
   output logic [DATA_W-1:0]    OutOperandA,
   output logic [DATA_W-1:0]    OutOperandB,
   output logic [NREG-1:0]      Pending
);
   logic [4:0]           opcode;
   logic [NREG_LOG2-1:0] rdst, rsrc1, rsrc2;
   logic                 hazard, accept;
   logic [NREG-1:0]      one, set_mask, clr_mask, pending_next;
   assign opcode = InInstr[15:11];
   assign rdst = InInstr[10:8];
   assign rsrc1 = InInstr[7:5];
   assign rsrc2 = InInstr[4:2];
   assign one = NREG'(1);
   assign RfReadRegister1 = rsrc1;
   assign RfReadRegister2 = rsrc2;
   // Hazard looks only at the registered scoreboard; a same-cycle writeback still stalls
   always_comb begin
      hazard = (opcode[3] && Pending[rsrc1]) || (opcode[2] && Pending[rsrc2]) || (opcode[4] && Pending[rdst]);
      InReady = !hazard && !Flush && (!OutValid || OutReady);
      accept = InValid && InReady;
      set_mask = (accept && opcode[4]) ? one << rdst : '0;
      clr_mask = (WbEnable ? one << WbRegister : '0) | ((Flush && OutValid && OutWrites) ? one << OutDst : '0);
      pending_next = (Pending & ~clr_mask) | set_mask;
   end
   // ID/EX register and scoreboard; a new accept overrides drain, flush kills the entry
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         OutValid <= 1'b0;
         OutOpcode <= '0;
         OutDst <= '0;
         OutWrites <= 1'b0;
         OutOperandA <= '0;
         OutOperandB <= '0;
         Pending <= '0;
      end else begin
         Pending <= pending_next;
         if (accept) begin
            OutValid <= 1'b1;
            OutOpcode <= opcode;
            OutDst <= rdst;
            OutWrites <= opcode[4];
            OutOperandA <= opcode[3] ? RfReadData1 : '0;
            OutOperandB <= opcode[2] ? RfReadData2 : {{(DATA_W-5){1'b0}}, InInstr[4:0]};
         end else if (Flush || OutReady) begin
            OutValid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed checks of decode, hazard stall, handshake and scoreboard
module tb_decode_issue_stage;
   logic        Clk = 0, Reset, InValid, InReady, WbEnable, Flush, OutValid, OutReady, OutWrites;
   logic [15:0] InInstr, RfReadData1, RfReadData2, OutOperandA, OutOperandB;
   logic [2:0]  RfReadRegister1, RfReadRegister2, WbRegister, OutDst;
   logic [4:0]  OutOpcode;
   logic [7:0]  Pending;
   int checks = 0, errors = 0;

   decode_issue_stage dut (
      .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InInstr(InInstr),
      .RfReadRegister1(RfReadRegister1), .RfReadRegister2(RfReadRegister2),
      .RfReadData1(RfReadData1), .RfReadData2(RfReadData2), .WbEnable(WbEnable),
      .WbRegister(WbRegister), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
      .OutOpcode(OutOpcode), .OutDst(OutDst), .OutWrites(OutWrites),
      .OutOperandA(OutOperandA), .OutOperandB(OutOperandB), .Pending(Pending)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] r1, input logic [4:0] lo);
      return {op, rd, r1, lo};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      OutReady = 1; InValid = 1;
      InInstr = mk(5'b10000, 3'd2, 3'd0, 5'd0);
      tick();
      InInstr = mk(5'b10000, 3'd5, 3'd0, 5'd0);
      tick();
      InValid = 0; OutReady = 0; InInstr = 16'h0000;
      checks++; if (Pending !== 8'h24) begin errors++; $display("FAIL pre_reset_pending got %h want 24", Pending); end
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", OutValid); end
      Reset = 1;
      #1;
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", OutValid); end
      checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", Pending); end
      checks++; if (OutOperandA !== 16'h0 || OutOperandB !== 16'h0 || OutDst !== 3'd0 || OutOpcode !== 5'd0 || OutWrites !== 1'b0)
         begin errors++; $display("FAIL reset_bundle got %h %h %h %h %b want zeros", OutOperandA, OutOperandB, OutDst, OutOpcode, OutWrites); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b want 1", InReady); end
      #1 Reset = 0;
      tick();
   endtask

   task automatic test_issue();
      InValid = 1; OutReady = 0;
      InInstr = mk(5'b11100, 3'd2, 3'd1, {3'd3, 2'b00});
      RfReadData1 = 16'h1234; RfReadData2 = 16'h00FF;
      #1;
      checks++; if (RfReadRegister1 !== 3'd1 || RfReadRegister2 !== 3'd3) begin errors++; $display("FAIL issue_rdaddr got %0d %0d want 1 3", RfReadRegister1, RfReadRegister2); end
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL issue_inready got %b want 1", InReady); end
      tick();
      InValid = 0;
      checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL issue_valid got %b want 1", OutValid); end
      checks++; if (OutOperandA !== 16'h1234 || OutOperandB !== 16'h00FF) begin errors++; $display("FAIL issue_operands got %h %h want 1234 00ff", OutOperandA, OutOperandB); end
      checks++; if (OutDst !== 3'd2 || OutOpcode !== 5'b11100 || OutWrites !== 1'b1) begin errors++; $display("FAIL issue_fields got %0d %b %b want 2 11100 1", OutDst, OutOpcode, OutWrites); end
      checks++; if (Pending !== 8'h04) begin errors++; $display("FAIL issue_pending got %h want 04", Pending); end
   endtask

   task automatic test_raw();
      InValid = 1; OutReady = 1;
      InInstr = mk(5'b01000, 3'd0, 3'd2, 5'd0);
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL raw_stall got %b want 0", InReady); end
      tick();
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL raw_drain got %b want 0", OutValid); end
      WbEnable = 1; WbRegister = 3'd2;
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL raw_wb_same_cycle got %b want 0", InReady); end
      tick();
      WbEnable = 0;
      checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL raw_wb_clear got %h want 00", Pending); end
      RfReadData1 = 16'hBEEF;
      #1;
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL raw_release got %b want 1", InReady); end
      tick();
      InValid = 0;
      checks++; if (OutValid !== 1'b1 || OutOperandA !== 16'hBEEF || OutOperandB !== 16'h0 || OutWrites !== 1'b0)
         begin errors++; $display("FAIL raw_issue got %b %h %h %b want 1 beef 0000 0", OutValid, OutOperandA, OutOperandB, OutWrites); end
   endtask

   task automatic test_imm();
      InValid = 1; OutReady = 1;
      InInstr = mk(5'b11000, 3'd6, 3'd1, 5'h1F);
      RfReadData1 = 16'h0A0A; RfReadData2 = 16'hFFFF;
      #1;
      checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL imm_inready got %b want 1", InReady); end
      tick();
      InValid = 0;
      checks++; if (OutOperandA !== 16'h0A0A || OutOperandB !== 16'h001F) begin errors++; $display("FAIL imm_operands got %h %h want 0a0a 001f", OutOperandA, OutOperandB); end
      checks++; if (Pending !== 8'h40) begin errors++; $display("FAIL imm_pending got %h want 40", Pending); end
      WbEnable = 1; WbRegister = 3'd6;
      tick();
      WbEnable = 0;
      checks++; if (OutValid !== 1'b0 || Pending !== 8'h00) begin errors++; $display("FAIL imm_cleanup got %b %h want 0 00", OutValid, Pending); end
   endtask

   task automatic test_hold_flush();
      OutReady = 0; InValid = 1;
      InInstr = mk(5'b10000, 3'd5, 3'd0, 5'h0B);
      tick();
      checks++; if (OutValid !== 1'b1 || Pending !== 8'h20) begin errors++; $display("FAIL hold_load got %b %h want 1 20", OutValid, Pending); end
      InInstr = mk(5'b10000, 3'd1, 3'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL hold_inready cycle %0d got %b want 0", i, InReady); end
         tick();
         checks++; if (OutValid !== 1'b1 || OutDst !== 3'd5 || OutOperandB !== 16'h000B || OutOpcode !== 5'b10000)
            begin errors++; $display("FAIL hold_stable cycle %0d got %b %0d %h %b want 1 5 000b 10000", i, OutValid, OutDst, OutOperandB, OutOpcode); end
      end
      Flush = 1;
      #1;
      checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL flush_inready got %b want 0", InReady); end
      tick();
      Flush = 0; InValid = 0;
      checks++; if (OutValid !== 1'b0 || Pending !== 8'h00) begin errors++; $display("FAIL flush_kill got %b %h want 0 00", OutValid, Pending); end
   endtask

   task automatic test_set_wins();
      InValid = 1; OutReady = 0;
      InInstr = mk(5'b10000, 3'd4, 3'd0, 5'd0);
      WbEnable = 1; WbRegister = 3'd4;
      tick();
      InValid = 0;
      checks++; if (Pending !== 8'h10 || OutValid !== 1'b1) begin errors++; $display("FAIL set_wins got %h %b want 10 1", Pending, OutValid); end
      OutReady = 1; WbRegister = 3'd3;
      tick();
      WbEnable = 0;
      checks++; if (Pending !== 8'h10 || OutValid !== 1'b0) begin errors++; $display("FAIL wb_harmless got %h %b want 10 0", Pending, OutValid); end
      Flush = 1;
      tick();
      Flush = 0;
      checks++; if (Pending !== 8'h10) begin errors++; $display("FAIL flush_idle got %h want 10", Pending); end
      WbEnable = 1; WbRegister = 3'd4;
      tick();
      WbEnable = 0;
      checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL wb_r4 got %h want 00", Pending); end
   endtask

   task automatic test_back_to_back();
      OutReady = 1; InValid = 1;
      for (int i = 0; i < 4; i++) begin
         InInstr = mk(5'b11100, 3'(i), 3'(7 - i), {3'd4, 2'b00});
         RfReadData1 = 16'h1000 + 16'(i); RfReadData2 = 16'h2000 + 16'(i);
         #1;
         checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_inready %0d got %b want 1", i, InReady); end
         tick();
         checks++; if (OutValid !== 1'b1 || OutDst !== 3'(i) || OutOperandA !== 16'h1000 + 16'(i) || OutOperandB !== 16'h2000 + 16'(i))
            begin errors++; $display("FAIL b2b_issue %0d got %b %0d %h %h want 1 %0d %h %h", i, OutValid, OutDst, OutOperandA, OutOperandB, i, 16'h1000 + 16'(i), 16'h2000 + 16'(i)); end
      end
      InValid = 0;
      checks++; if (Pending !== 8'h0F) begin errors++; $display("FAIL b2b_pending got %h want 0f", Pending); end
      tick();
      checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", OutValid); end
   endtask

   initial begin
      Reset = 1; InValid = 0; InInstr = 0; RfReadData1 = 0; RfReadData2 = 0;
      WbEnable = 0; WbRegister = 0; Flush = 0; OutReady = 0;
      tick(); tick();
      Reset = 0;
      tick();
      test_reset();
      test_issue();
      test_raw();
      test_imm();
      test_hold_flush();
      test_set_wins();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
